uart_tx: RTL and testbench

// - UART serial transmitter: accepts a parallel word via a valid/ready handshake and shifts it out on one line.
// - Frame format: start bit, BITS_N data bits LSB-first, optional parity, stop bit(s).
// - Sits between on-chip producers (debug/telemetry FSMs) and the board UART TX pin. Single clock domain.

---
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, BITS_N data bits LSB-first, optional parity, stop bit(s).
// A word is accepted on a valid/tx_ready handshake. All outputs are registered.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,  // clock cycles per serial bit, >= 2
  parameter int unsigned BITS_N       = 8,    // data bits per frame, 5..9
  parameter int unsigned PARITY       = 0,    // 0 = none, 1 = odd, 2 = even
  parameter int unsigned STOP_BITS    = 1     // 1 or 2
) (
  input  logic              clk,
  input  logic              reset,     // asynchronous, active-low
  input  logic [BITS_N-1:0] data_tx,
  input  logic              valid,
  output logic              uart_out,
  output logic              tx_ready
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CntW  = $clog2(BITS_N + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  DataLast = CntW'(BITS_N - 1);
  localparam logic [CntW-1:0]  StopLast = CntW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BITS_N-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              uart_out_q, uart_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              bit_done;

  assign bit_done = (baud_q == BaudLast);

  // Next-state: handshake capture, baud timing, bit sequencing.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    if (state_q != StIdle) begin
      // Baud counter wraps at every bit boundary so frames never drift.
      baud_d = bit_done ? '0 : baud_q + BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (valid && tx_ready_q) begin
          state_d   = StStart;
          shift_d   = data_tx;
          baud_d    = '0;
          bit_cnt_d = '0;
          if (PARITY == 1) begin
            parity_d = ~^data_tx;
          end else if (PARITY == 2) begin
            parity_d = ^data_tx;
          end else begin
            parity_d = 1'b0;
          end
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (bit_cnt_q == StopLast) begin
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    uart_out_d = 1'b1;
    tx_ready_d = 1'b0;
    unique case (state_d)
      StIdle:   tx_ready_d = 1'b1;
      StStart:  uart_out_d = 1'b0;
      StData:   uart_out_d = shift_d[0];
      StParity: uart_out_d = parity_d;
      StStop:   uart_out_d = 1'b1;
      default:  uart_out_d = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame and returns the line to mark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      uart_out_q <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      uart_out_q <= uart_out_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign uart_out = uart_out_q;
  assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of sent bytes decoded by a bit-centre monitor,
// plus direct frame timing, back-to-back, mid-frame reset and parity checks.
module tb_uart_tx;

  localparam int unsigned Cpb         = 434;
  localparam int unsigned PCpb        = 4;
  localparam int unsigned FrameCycles = 10 * Cpb;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_tx;
  logic       valid;
  logic       uart_out;
  logic       tx_ready;

  logic [7:0] p_data;
  logic       p_valid;
  logic       pe_out, pe_ready;
  logic       po_out, po_ready;

  int checks   = 0;
  int failures = 0;
  int frames_seen = 0;
  bit mon_en = 1'b1;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .BITS_N      (8),
    .PARITY      (0),
    .STOP_BITS   (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_tx (data_tx),
    .valid   (valid),
    .uart_out(uart_out),
    .tx_ready(tx_ready)
  );

  uart_tx #(
    .CLKS_PER_BIT(PCpb),
    .BITS_N      (8),
    .PARITY      (2),
    .STOP_BITS   (1)
  ) dut_even (
    .clk     (clk),
    .reset   (reset),
    .data_tx (p_data),
    .valid   (p_valid),
    .uart_out(pe_out),
    .tx_ready(pe_ready)
  );

  uart_tx #(
    .CLKS_PER_BIT(PCpb),
    .BITS_N      (8),
    .PARITY      (1),
    .STOP_BITS   (1)
  ) dut_odd (
    .clk     (clk),
    .reset   (reset),
    .data_tx (p_data),
    .valid   (p_valid),
    .uart_out(po_out),
    .tx_ready(po_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit 0 is the start bit, bit 9 the stop bit.
  function automatic logic [9:0] frame_8n1(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic [10:0] frame_8p1(input logic [7:0] b, input bit odd);
    logic par;
    par = 1'b0;
    for (int i = 0; i < 8; i++) par = par ^ b[i];
    if (odd) par = ~par;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Wait for idle (bounded), present one word for a single edge.
  task automatic send(input logic [7:0] b, input bit push);
    int waited;
    waited = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && waited < 3 * FrameCycles) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) check_eq("send_ready_timeout", {31'd0, tx_ready}, 32'd1);
    data_tx = b;
    valid   = 1'b1;
    if (push) sb_q.push_back(b);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Monitor: decode frames at bit centres and compare against the scoreboard.
  initial begin : monitor
    logic       prev;
    logic [7:0] got;
    logic [7:0] exp;
    prev = 1'b1;
    got  = '0;
    forever begin
      @(negedge clk);
      if (mon_en && reset && prev && !uart_out) begin
        repeat (Cpb / 2 - 1) @(negedge clk);
        check_eq("mon_start_bit", {31'd0, uart_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          got[i] = uart_out;
        end
        repeat (Cpb) @(negedge clk);
        check_eq("mon_stop_bit", {31'd0, uart_out}, 32'd1);
        frames_seen++;
        if (sb_q.size() == 0) begin
          check_eq("mon_unexpected_frame", 32'(sb_q.size()), 32'd1);
        end else begin
          exp = sb_q.pop_front();
          check_eq("mon_byte", {24'd0, got}, {24'd0, exp});
        end
      end
      prev = uart_out;
    end
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [9:0]  f;
    logic [10:0] pe_bits, po_bits, pe_exp, po_exp;
    int bad;
    int w;
    int idx;

    reset   = 1'b0;
    valid   = 1'b0;
    data_tx = '0;
    p_valid = 1'b0;
    p_data  = '0;
    pe_bits = '0;
    po_bits = '0;

    // Reset and idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_out", {31'd0, uart_out}, 32'd1);
    check_eq("rst_hold_ready", {31'd0, tx_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_out", {31'd0, uart_out}, 32'd1);
    check_eq("rst_rel_ready", {31'd0, tx_ready}, 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_out !== 1'b1 || tx_ready !== 1'b1) bad++;
    end
    check_eq("idle_stable", 32'(bad), 32'd0);

    // 'a' with exact per-cycle line and tx_ready timing
    send(8'h61, 1'b1);
    f = frame_8n1(8'h61);
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < int'(Cpb); c++) begin
        @(negedge clk);
        if (uart_out !== f[k]) bad++;
        if (k == 0 && c == 0) check_eq("ready_drop", {31'd0, tx_ready}, 32'd0);
        if (k == 9 && c == int'(Cpb) - 1) check_eq("ready_before_end", {31'd0, tx_ready}, 32'd0);
      end
      check_eq($sformatf("a_bit%0d_cycles_wrong", k), 32'(bad), 32'd0);
    end
    @(negedge clk);
    check_eq("ready_after_frame", {31'd0, tx_ready}, 32'd1);
    check_eq("line_after_frame", {31'd0, uart_out}, 32'd1);

    // 'b' with a mid-frame valid pulse that must be ignored
    send(8'h62, 1'b1);
    repeat (1000) @(negedge clk);
    check_eq("busy_ready", {31'd0, tx_ready}, 32'd0);
    data_tx = 8'hFF;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    data_tx = 8'h00;

    // 'c' then 'd' with valid held high: one idle clock between frames
    send(8'h63, 1'b1);
    @(negedge clk);
    data_tx = 8'h64;
    valid   = 1'b1;
    sb_q.push_back(8'h64);
    w = 0;
    while (tx_ready !== 1'b1 && w < 2 * int'(FrameCycles)) begin
      @(negedge clk);
      w++;
    end
    check_eq("b2b_frame_len", 32'(w), FrameCycles);
    check_eq("b2b_gap_line", {31'd0, uart_out}, 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_start", {31'd0, uart_out}, 32'd0);
    check_eq("b2b_busy", {31'd0, tx_ready}, 32'd0);
    repeat (2 * FrameCycles + 100) @(negedge clk);
    check_eq("frames_abcd", 32'(frames_seen), 32'd4);
    check_eq("sb_empty_abcd", 32'(sb_q.size()), 32'd0);

    // Reset during data bit 3 of an aborted byte, then a clean 0xA5
    mon_en = 1'b0;
    send(8'h33, 1'b0);
    repeat (4 * Cpb + Cpb / 2) @(negedge clk);
    check_eq("pre_rst_bit3", {31'd0, uart_out}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_out", {31'd0, uart_out}, 32'd1);
    check_eq("rst_async_ready", {31'd0, tx_ready}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (2 * Cpb) begin
      @(negedge clk);
      if (uart_out !== 1'b1 || tx_ready !== 1'b1) bad++;
    end
    check_eq("post_rst_idle", 32'(bad), 32'd0);
    mon_en = 1'b1;
    send(8'hA5, 1'b1);
    repeat (FrameCycles + 100) @(negedge clk);
    check_eq("frames_total", 32'(frames_seen), 32'd5);
    check_eq("sb_empty_end", 32'(sb_q.size()), 32'd0);

    // Parity variants, 0x07: even parity bit 1, odd parity bit 0, 11-bit frame
    @(negedge clk);
    p_data  = 8'h07;
    p_valid = 1'b1;
    @(posedge clk);
    #1 p_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 11 * int'(PCpb); c++) begin
      @(negedge clk);
      if ((c - 1) % int'(PCpb) == int'(PCpb) / 2) begin
        idx = (c - 1) / int'(PCpb);
        pe_bits[idx] = pe_out;
        po_bits[idx] = po_out;
      end
      if (pe_ready !== 1'b0 || po_ready !== 1'b0) bad++;
    end
    pe_exp = frame_8p1(8'h07, 1'b0);
    po_exp = frame_8p1(8'h07, 1'b1);
    check_eq("even_frame", {21'd0, pe_bits}, {21'd0, pe_exp});
    check_eq("odd_frame", {21'd0, po_bits}, {21'd0, po_exp});
    check_eq("even_parity_bit", {31'd0, pe_bits[9]}, 32'd1);
    check_eq("odd_parity_bit", {31'd0, po_bits[9]}, 32'd0);
    check_eq("parity_busy_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    check_eq("even_ready_end", {31'd0, pe_ready}, 32'd1);
    check_eq("odd_ready_end", {31'd0, po_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
